// File: rtl/decode_buffer.sv
// decode_buffer: DEPTH-entry {instr, pc} queue that decodes its head MIPS instruction for execute
module decode_buffer #(
  parameter int DEPTH = 4,
  parameter bit BRANCH_EXT = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [31:0]             in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [8:0]              out_control,
  output logic [4:0]              out_rs,
  output logic [4:0]              out_rt,
  output logic [4:0]              out_shamt,
  output logic [4:0]              out_rd,
  output logic [31:0]             out_imm,
  output logic [2:0]              out_branch,
  output logic [31:0]             out_target,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [13:0] BR_CW = 14'b1_10_00_0_0_1_1110_0_0;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [31:0] hi, hp, pc4, ext, imm, tgt;
  logic [5:0] op, fn;
  logic [13:0] cw;
  logic [2:0] br;
  logic bad, cb;
  logic [4:0] rd;

  assign in_ready = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + (AW+1)'(1) : (!push && pop) ? count - (AW+1)'(1) : count;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q[wr_ptr] <= in_instr;
      pc_q[wr_ptr] <= in_pc;
    end
  end

  assign hi = instr_q[rd_ptr];
  assign hp = pc_q[rd_ptr];
  assign op = hi[31:26];
  assign fn = hi[5:0];

  always_comb begin
    cw = '0;
    br = 3'd0;
    bad = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h21: cw = 14'b0_00_01_1_0_0_0000_0_0;
        6'h23: cw = 14'b0_00_01_1_0_0_0001_0_0;
        6'h24: cw = 14'b0_00_01_1_0_0_0010_0_0;
        6'h25: cw = 14'b0_00_01_1_0_0_0011_0_0;
        6'h27: cw = 14'b0_00_01_1_0_0_0100_0_0;
        6'h26: cw = 14'b0_00_01_1_0_0_0101_0_0;
        6'h00: cw = 14'b0_00_01_1_1_0_0110_0_0;
        6'h03: cw = 14'b0_00_01_1_1_0_0111_0_0;
        6'h02: cw = 14'b0_00_01_1_1_0_1000_0_0;
        6'h2A: cw = 14'b0_00_01_1_0_0_1001_0_0;
        6'h2B: cw = 14'b0_00_01_1_0_0_1010_0_0;
        6'h08: br = 3'd7;
        default: bad = 1'b1;
      endcase
      6'h09: cw = 14'b1_00_10_1_0_1_0000_0_0;
      6'h0C: cw = 14'b0_00_10_1_0_1_0010_0_0;
      6'h0D: cw = 14'b0_00_10_1_0_1_0011_0_0;
      6'h0E: cw = 14'b0_00_10_1_0_1_0101_0_0;
      6'h0A: cw = 14'b1_00_10_1_0_1_1001_0_0;
      6'h0B: cw = 14'b1_00_10_1_0_1_1010_0_0;
      6'h0F: cw = 14'b0_01_10_1_0_1_1111_0_0;
      6'h23: cw = 14'b1_00_10_1_0_1_0000_1_0;
      6'h2B: cw = 14'b1_00_00_0_0_1_0000_0_1;
      6'h04: begin cw = BR_CW; br = 3'd1; end
      6'h05: begin cw = BR_CW; br = 3'd2; end
      6'h06: if (BRANCH_EXT) begin cw = BR_CW; br = 3'd3; end else bad = 1'b1;
      6'h07: if (BRANCH_EXT) begin cw = BR_CW; br = 3'd4; end else bad = 1'b1;
      6'h01: if (BRANCH_EXT && hi[20:17] == 4'd0) begin cw = BR_CW; br = hi[16] ? 3'd6 : 3'd5; end else bad = 1'b1;
      6'h02: br = 3'd7;
      6'h03: begin cw = 14'b0_11_11_1_0_1_1111_0_0; br = 3'd7; end
      default: bad = 1'b1;
    endcase
  end

  assign cb = br != 3'd0 && br != 3'd7;
  assign pc4 = hp + 32'd4;
  assign ext = cw[13] ? {{16{hi[15]}}, hi[15:0]} : {16'h0, hi[15:0]};
  assign imm = cw[12:11] == 2'b00 ? ext : cw[12:11] == 2'b01 ? {ext[15:0], 16'h0} :
               cw[12:11] == 2'b10 ? {ext[29:0], 2'b00} : hp + 32'd8;
  assign rd = cw[10:9] == 2'b00 ? 5'd0 : cw[10:9] == 2'b01 ? hi[15:11] : cw[10:9] == 2'b10 ? hi[20:16] : 5'd31;
  assign tgt = cb ? pc4 + {{14{hi[15]}}, hi[15:0], 2'b00} :
               (br == 3'd7 && op != 6'h00) ? {pc4[31:28], hi[25:0], 2'b00} : 32'h0;

  assign out_pc = out_valid ? hp : '0;
  assign out_control = out_valid ? cw[8:0] : '0;
  assign out_rs = out_valid ? hi[25:21] : '0;
  assign out_rt = out_valid ? hi[20:16] : '0;
  assign out_shamt = out_valid ? hi[10:6] : '0;
  assign out_rd = out_valid ? rd : '0;
  assign out_imm = (out_valid && !bad) ? imm : '0;
  assign out_branch = out_valid ? br : '0;
  assign out_target = out_valid ? tgt : '0;
  assign out_illegal = out_valid & bad;
endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: queue/decode model check of decode_buffer with and without extended branches
module tb_decode_buffer;
  logic clk = 1'b0;
  logic resetn, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic o0_in_ready, o0_out_valid, o0_ill, o1_in_ready, o1_out_valid, o1_ill;
  logic [31:0] o0_pc, o0_imm, o0_tgt, o1_pc, o1_imm, o1_tgt;
  logic [8:0] o0_ctl, o1_ctl;
  logic [4:0] o0_rs, o0_rt, o0_sh, o0_rd, o1_rs, o1_rt, o1_sh, o1_rd;
  logic [2:0] o0_br, o1_br, o0_count, o1_count;
  int passed = 0, total = 0;

  typedef enum {ILL, ADDU, SUBU, AND, OR, NOR, XOR, SLL, SRA, SRL, SLT, SLTU, JR,
                ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ,
                LW, SW, J, JAL} mn_t;
  typedef struct packed {
    logic [8:0] ctl;
    logic [4:0] rd;
    logic [31:0] imm;
    logic [2:0] br;
    logic [31:0] tgt;
    logic ill;
  } dec_t;

  logic [63:0] q [$];

  always #5 clk = ~clk;

  decode_buffer #(.DEPTH(4), .BRANCH_EXT(1'b0)) d0 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_pc(o0_pc), .out_control(o0_ctl), .out_rs(o0_rs), .out_rt(o0_rt), .out_shamt(o0_sh),
    .out_rd(o0_rd), .out_imm(o0_imm), .out_branch(o0_br), .out_target(o0_tgt),
    .out_illegal(o0_ill), .count(o0_count));

  decode_buffer #(.DEPTH(4), .BRANCH_EXT(1'b1)) d1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_pc(o1_pc), .out_control(o1_ctl), .out_rs(o1_rs), .out_rt(o1_rt), .out_shamt(o1_sh),
    .out_rd(o1_rd), .out_imm(o1_imm), .out_branch(o1_br), .out_target(o1_tgt),
    .out_illegal(o1_ill), .count(o1_count));

  function automatic mn_t ident(input logic [31:0] i, input bit ext);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00)
      case (fn)
        6'h21: return ADDU;   6'h23: return SUBU;  6'h24: return AND;  6'h25: return OR;
        6'h27: return NOR;    6'h26: return XOR;   6'h00: return SLL;  6'h03: return SRA;
        6'h02: return SRL;    6'h2A: return SLT;   6'h2B: return SLTU; 6'h08: return JR;
        default: return ILL;
      endcase
    case (op)
      6'h09: return ADDIU;  6'h0C: return ANDI;  6'h0D: return ORI;  6'h0E: return XORI;
      6'h0A: return SLTI;   6'h0B: return SLTIU; 6'h0F: return LUI;  6'h04: return BEQ;
      6'h05: return BNE;    6'h23: return LW;    6'h2B: return SW;   6'h02: return J;
      6'h03: return JAL;
      6'h06: return ext ? BLEZ : ILL;
      6'h07: return ext ? BGTZ : ILL;
      6'h01: return (ext && i[20:16] == 5'd0) ? BLTZ : (ext && i[20:16] == 5'd1) ? BGEZ : ILL;
      default: return ILL;
    endcase
  endfunction

  function automatic logic [3:0] fcode(input mn_t m);
    case (m)
      SUBU: return 4'd1;
      AND, ANDI: return 4'd2;
      OR, ORI: return 4'd3;
      NOR: return 4'd4;
      XOR, XORI: return 4'd5;
      SLL: return 4'd6;
      SRA: return 4'd7;
      SRL: return 4'd8;
      SLT, SLTI: return 4'd9;
      SLTU, SLTIU: return 4'd10;
      BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ: return 4'd14;
      LUI, JAL: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] bclass(input mn_t m);
    case (m)
      BEQ: return 3'd1;
      BNE: return 3'd2;
      BLEZ: return 3'd3;
      BGTZ: return 3'd4;
      BLTZ: return 3'd5;
      BGEZ: return 3'd6;
      J, JAL, JR: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] i, input logic [31:0] pc, input bit ext);
    dec_t d;
    mn_t m;
    bit ralu, ialu, cbr, sx, wr;
    logic [31:0] se, ze, x, pc4;
    d = '0;
    m = ident(i, ext);
    if (m == ILL) begin
      d.ill = 1'b1;
      return d;
    end
    ralu = m inside {ADDU, SUBU, AND, OR, NOR, XOR, SLL, SRA, SRL, SLT, SLTU};
    ialu = m inside {ADDIU, ANDI, ORI, XORI, SLTI, SLTIU};
    cbr = m inside {BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ};
    sx = cbr || m inside {ADDIU, SLTI, SLTIU, LW, SW};
    wr = ralu || ialu || m inside {LUI, LW, JAL};
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    x = sx ? se : ze;
    pc4 = pc + 32'd4;
    d.ctl = {wr, m inside {SLL, SRA, SRL}, ialu || cbr || m inside {LUI, LW, SW, JAL},
             fcode(m), m == LW, m == SW};
    d.rd = ralu ? i[15:11] : (ialu || m inside {LUI, LW}) ? i[20:16] : (m == JAL) ? 5'd31 : 5'd0;
    d.imm = (m == LUI) ? x << 16 : cbr ? x << 2 : (m == JAL) ? pc + 32'd8 : x;
    d.br = bclass(m);
    d.tgt = cbr ? pc4 + (se << 2) : (m inside {J, JAL}) ? {pc4[31:28], i[25:0], 2'b00} : 32'h0;
    return d;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  task automatic cmp(input string t, input bit ext, input logic [2:0] c, input logic ir, input logic ov,
                     input logic [31:0] pc, input logic [8:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] sh, input logic [4:0] rd, input logic [31:0] imm,
                     input logic [2:0] br, input logic [31:0] tg, input logic il);
    dec_t e;
    logic [31:0] hi, hp;
    bit v;
    v = q.size() != 0;
    hi = v ? q[0][63:32] : 32'h0;
    hp = v ? q[0][31:0] : 32'h0;
    e = v ? decode(hi, hp, ext) : '0;
    chk({t, ".count"}, 32'(c), 32'(q.size()));
    chk({t, ".in_ready"}, 32'(ir), 32'(q.size() < 4));
    chk({t, ".out_valid"}, 32'(ov), 32'(v));
    chk({t, ".pc"}, pc, hp);
    chk({t, ".control"}, 32'(ctl), 32'(e.ctl));
    chk({t, ".rs"}, 32'(rs), 32'(hi[25:21]));
    chk({t, ".rt"}, 32'(rt), 32'(hi[20:16]));
    chk({t, ".shamt"}, 32'(sh), 32'(hi[10:6]));
    chk({t, ".rd"}, 32'(rd), 32'(e.rd));
    chk({t, ".imm"}, imm, e.imm);
    chk({t, ".branch"}, 32'(br), 32'(e.br));
    chk({t, ".target"}, tg, e.tgt);
    chk({t, ".illegal"}, 32'(il), 32'(e.ill));
  endtask

  always @(posedge clk or negedge resetn) begin
    bit pu, po;
    if (!resetn || flush) q.delete();
    else begin
      pu = in_valid && q.size() < 4;
      po = out_ready && q.size() > 0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back({in_instr, in_pc});
    end
  end

  always @(negedge clk) begin
    cmp("d0", 1'b0, o0_count, o0_in_ready, o0_out_valid, o0_pc, o0_ctl, o0_rs, o0_rt, o0_sh, o0_rd,
        o0_imm, o0_br, o0_tgt, o0_ill);
    cmp("d1", 1'b1, o1_count, o1_in_ready, o1_out_valid, o1_pc, o1_ctl, o1_rs, o1_rt, o1_sh, o1_rd,
        o1_imm, o1_br, o1_tgt, o1_ill);
  end

  task automatic cyc(input bit v, input logic [31:0] i, input logic [31:0] p, input bit r, input bit f = 1'b0);
    in_valid = v;
    in_instr = i;
    in_pc = p;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [$];

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h2408FFFF; in_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(o0_in_ready), 32'd1);
    chk("rst.out_valid", 32'(o0_out_valid), 32'd0);
    chk("rst.count", 32'(o0_count), 32'd0);
    chk("rst.control", 32'(o0_ctl), 32'd0);
    resetn = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst.still_empty", 32'(o0_count), 32'd0);

    cyc(1'b1, 32'h2408FFFF, 32'hBFC00000, 1'b0);
    chk("addiu.valid", 32'(o0_out_valid), 32'd1);
    chk("addiu.rd", 32'(o0_rd), 32'd8);
    chk("addiu.imm", o0_imm, 32'hFFFFFFFF);
    chk("addiu.control", 32'(o0_ctl), 32'h140);
    chk("addiu.illegal", 32'(o0_ill), 32'd0);
    chk("addiu.pc", o0_pc, 32'hBFC00000);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("addiu.popped", 32'(o0_count), 32'd0);

    cyc(1'b1, 32'h00221821, 32'h1000, 1'b0);
    cyc(1'b1, 32'h3C051234, 32'h1004, 1'b0);
    cyc(1'b1, 32'h8CE6FFFC, 32'h1008, 1'b0);
    cyc(1'b1, 32'hACE60008, 32'h100C, 1'b0);
    chk("full.count", 32'(o0_count), 32'd4);
    chk("full.in_ready", 32'(o0_in_ready), 32'd0);
    chk("full.head", o0_pc, 32'h1000);
    cyc(1'b1, 32'h3421ABCD, 32'h1010, 1'b0);
    chk("full.refused", 32'(o0_count), 32'd4);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("full.in_ready_back", 32'(o0_in_ready), 32'd1);
    chk("full.head2", o0_pc, 32'h1004);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("lw.control", 32'(o0_ctl), 32'h142);
    chk("lw.imm", o0_imm, 32'hFFFFFFFC);
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("full.drained", 32'(o0_count), 32'd0);

    cyc(1'b1, 32'h00221823, 32'h2000, 1'b0);
    cyc(1'b1, 32'h00221824, 32'h2004, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, (k % 2) ? 32'h00221825 : 32'h0022182A, 32'h2008 + 32'(4 * k), 1'b1);
      chk("stream.count", 32'(o0_count), 32'd2);
    end
    chk("stream.head", o0_pc, 32'h2020);
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b1);

    cyc(1'b1, 32'h0C000010, 32'h80000000, 1'b0);
    chk("jal.rd", 32'(o0_rd), 32'd31);
    chk("jal.imm", o0_imm, 32'h80000008);
    chk("jal.branch", 32'(o0_br), 32'd7);
    chk("jal.target", o0_tgt, 32'h80000040);
    chk("jal.control", 32'(o0_ctl), 32'h17C);
    cyc(1'b1, 32'h1000FFFF, 32'h100, 1'b1);
    chk("beq.target", o0_tgt, 32'h100);
    chk("beq.branch", 32'(o0_br), 32'd1);
    chk("beq.control", 32'(o0_ctl), 32'h078);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);

    cyc(1'b1, 32'h18800003, 32'h200, 1'b0);
    chk("blez0.illegal", 32'(o0_ill), 32'd1);
    chk("blez0.control", 32'(o0_ctl), 32'd0);
    chk("blez0.imm", o0_imm, 32'd0);
    chk("blez1.branch", 32'(o1_br), 32'd3);
    chk("blez1.target", o1_tgt, 32'h210);
    chk("blez1.illegal", 32'(o1_ill), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);

    tbl = '{32'h00221821, 32'h00221823, 32'h00221824, 32'h00221825, 32'h00221827, 32'h00221826,
            32'h000220C0, 32'h000220C3, 32'h000220C2, 32'h0022182A, 32'h0022182B, 32'h03E00008,
            32'h2408FFFF, 32'h3021FFFF, 32'h3421ABCD, 32'h38210F0F, 32'h2821FFFF, 32'h2C218000,
            32'h3C051234, 32'h8CE6FFFC, 32'hACE60008, 32'h14220004, 32'h1000FFFF, 32'h1C80FFFE,
            32'h04800001, 32'h04810001, 32'h04820001, 32'h08100000, 32'h0C000010, 32'hFC000000,
            32'h0000003F, 32'h18800003};
    foreach (tbl[k]) cyc(1'b1, tbl[k], 32'hF0000000 + 32'(8 * k), 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);

    cyc(1'b1, 32'h00221821, 32'h3000, 1'b0);
    cyc(1'b1, 32'h00221823, 32'h3004, 1'b0);
    cyc(1'b1, 32'h00221824, 32'h3008, 1'b0);
    cyc(1'b1, 32'h00221825, 32'h300C, 1'b1, 1'b1);
    chk("flush.count", 32'(o0_count), 32'd0);
    chk("flush.out_valid", 32'(o1_out_valid), 32'd0);
    chk("flush.in_ready", 32'(o0_in_ready), 32'd1);
    cyc(1'b1, 32'h3421ABCD, 32'h5000, 1'b0);
    chk("after_flush.count", 32'(o0_count), 32'd1);
    chk("after_flush.head", o0_pc, 32'h5000);

    cyc(1'b1, 32'h38210F0F, 32'h5004, 1'b0);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst.count", 32'(o0_count), 32'd0);
    chk("async_rst.out_valid", 32'(o1_out_valid), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("async_rst.empty", 32'(o0_count), 32'd0);
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
